// File: rtl/beta_pkg.sv
// beta_pkg: shared encodings for the BETA control sequencer
// Holds the OPCLASS, PCSEL, WDSEL and TRAP_CAUSE codes and the sequencer state type.
package beta_pkg;
  localparam logic [2:0] OP_ALU = 3'd0;
  localparam logic [2:0] OP_LD  = 3'd1;
  localparam logic [2:0] OP_ST  = 3'd2;
  localparam logic [2:0] OP_LDR = 3'd3;
  localparam logic [2:0] OP_BEQ = 3'd4;
  localparam logic [2:0] OP_BNE = 3'd5;
  localparam logic [2:0] OP_JMP = 3'd6;
  localparam logic [2:0] OP_ILL = 3'd7;

  localparam logic [2:0] PCSEL_INC    = 3'd0;
  localparam logic [2:0] PCSEL_OFFSET = 3'd1;
  localparam logic [2:0] PCSEL_JT     = 3'd2;
  localparam logic [2:0] PCSEL_ILLOP  = 3'd3;
  localparam logic [2:0] PCSEL_XADR   = 3'd4;

  localparam logic [1:0] WDSEL_PCINC = 2'd0;
  localparam logic [1:0] WDSEL_ALU   = 2'd1;
  localparam logic [1:0] WDSEL_MEM   = 2'd2;

  localparam logic [1:0] CAUSE_NONE   = 2'd0;
  localparam logic [1:0] CAUSE_ILLOP  = 2'd1;
  localparam logic [1:0] CAUSE_BUSERR = 2'd2;
  localparam logic [1:0] CAUSE_IRQ    = 2'd3;

  typedef enum logic [2:0] {S_FETCH, S_EXEC, S_MEM, S_WB, S_TRAP, S_IRQ} state_t;
endpackage

// File: rtl/beta_irq_latch.sv
// beta_irq_latch: interrupt rising-edge capture with a sticky pending flag
// Ports: i_clk clock; i_rst_n async active-low reset; i_irq level request;
// i_clr clears pending (a new edge in the same cycle wins); o_pend pending flag.
module beta_irq_latch (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_irq,
  input  logic i_clr,
  output logic o_pend
);
  logic r_irq_d, r_pend;
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_irq_d <= 1'b0;
      r_pend  <= 1'b0;
    end else begin
      r_irq_d <= i_irq;
      r_pend  <= (i_irq && !r_irq_d) || (r_pend && !i_clr);
    end
  assign o_pend = r_pend;
endmodule

// File: rtl/beta_pc_sequencer.sv
// beta_pc_sequencer: multi-cycle fetch/exec/mem/writeback control FSM for the BETA core
// Ports: CLK, RESET_N (async active-low); OPCLASS, Z, PC31 decode/status inputs; IRQ external
// interrupt; IMEM_RDY, DMEM_RDY memory handshakes; PCSEL, PC_EN PC-unit control; IR_LD,
// IMEM_REQ fetch; DMEM_REQ, DMEM_WE data access; WERF, WASEL, WDSEL register-file write;
// TRAP_CAUSE cause of last trap; INSTR_CNT retired-instruction count.
module beta_pc_sequencer
  import beta_pkg::*;
#(
  parameter int TIMEOUT = 255,
  parameter int TO_W    = 8
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic [2:0]  OPCLASS,
  input  logic        Z,
  input  logic        PC31,
  input  logic        IRQ,
  input  logic        IMEM_RDY,
  input  logic        DMEM_RDY,
  output logic [2:0]  PCSEL,
  output logic        PC_EN,
  output logic        IR_LD,
  output logic        IMEM_REQ,
  output logic        DMEM_REQ,
  output logic        DMEM_WE,
  output logic        WERF,
  output logic        WASEL,
  output logic [1:0]  WDSEL,
  output logic [1:0]  TRAP_CAUSE,
  output logic [31:0] INSTR_CNT
);
  state_t          r_state, w_nxt;
  logic [2:0]      r_op, w_op, r_pcsel, w_wb_pcsel;
  logic            r_z, w_z, w_pend, w_clr, w_wait, w_rdy, w_to, w_wb_werf;
  logic            r_pc_en, r_imem_req, r_dmem_req, r_dmem_we, r_werf, r_wasel;
  logic [1:0]      r_wdsel, r_cause, w_wb_wdsel;
  logic [TO_W-1:0] r_to;
  logic [31:0]     r_cnt;

  assign w_clr = r_state == S_IRQ;

  beta_irq_latch u_irq (
    .i_clk  (CLK),
    .i_rst_n(RESET_N),
    .i_irq  (IRQ),
    .i_clr  (w_clr),
    .o_pend (w_pend)
  );

  // The first FETCH cycle after reset has no request on the bus yet, so a ready
  // there is ignored; waiting and loading only count once the request is up.
  assign w_wait = (r_state == S_FETCH && r_imem_req) || r_state == S_MEM;
  assign w_rdy  = r_state == S_FETCH ? IMEM_RDY : DMEM_RDY;
  assign w_to   = TIMEOUT != 0 && w_wait && !w_rdy && r_to == TO_W'(TIMEOUT - 1);

  // OPCLASS and Z are only valid in EXEC; later states use the captured copies.
  assign w_op = r_state == S_EXEC ? OPCLASS : r_op;
  assign w_z  = r_state == S_EXEC ? Z : r_z;

  assign w_wb_pcsel = w_op == OP_JMP ? PCSEL_JT :
                      w_op == OP_BEQ ? (w_z ? PCSEL_OFFSET : PCSEL_INC) :
                      w_op == OP_BNE ? (w_z ? PCSEL_INC : PCSEL_OFFSET) : PCSEL_INC;
  assign w_wb_werf  = w_op != OP_ST;
  assign w_wb_wdsel = w_op == OP_ALU ? WDSEL_ALU :
                      (w_op == OP_LD || w_op == OP_LDR) ? WDSEL_MEM : WDSEL_PCINC;

  always_comb begin
    w_nxt = S_FETCH;
    case (r_state)
      S_FETCH: w_nxt = w_to ? S_TRAP : (r_imem_req && IMEM_RDY) ? S_EXEC : S_FETCH;
      S_EXEC:  w_nxt = OPCLASS == OP_ILL ? S_TRAP :
                       (OPCLASS inside {OP_LD, OP_ST, OP_LDR}) ? S_MEM : S_WB;
      S_MEM:   w_nxt = w_to ? S_TRAP : DMEM_RDY ? S_WB : S_MEM;
      S_WB:    w_nxt = (w_pend && !PC31) ? S_IRQ : S_FETCH;
      default: w_nxt = S_FETCH;
    endcase
  end

  // Outputs are registered from the next state so each state's controls are
  // valid for the whole cycle spent in it.
  always_ff @(posedge CLK or negedge RESET_N)
    if (!RESET_N) begin
      r_state    <= S_FETCH;
      r_op       <= OP_ALU;
      r_z        <= 1'b0;
      r_to       <= '0;
      r_pcsel    <= PCSEL_INC;
      r_pc_en    <= 1'b0;
      r_imem_req <= 1'b0;
      r_dmem_req <= 1'b0;
      r_dmem_we  <= 1'b0;
      r_werf     <= 1'b0;
      r_wasel    <= 1'b0;
      r_wdsel    <= WDSEL_PCINC;
      r_cause    <= CAUSE_NONE;
      r_cnt      <= '0;
    end else begin
      r_state    <= w_nxt;
      r_op       <= w_op;
      r_z        <= w_z;
      r_to       <= w_nxt != r_state ? '0 : (w_wait && r_to != '1) ? r_to + TO_W'(1) : r_to;
      r_pcsel    <= w_nxt == S_WB ? w_wb_pcsel : w_nxt == S_TRAP ? PCSEL_ILLOP :
                    w_nxt == S_IRQ ? PCSEL_XADR : PCSEL_INC;
      r_pc_en    <= w_nxt inside {S_WB, S_TRAP, S_IRQ};
      r_imem_req <= w_nxt == S_FETCH;
      r_dmem_req <= w_nxt == S_MEM;
      r_dmem_we  <= w_nxt == S_MEM && w_op == OP_ST;
      r_werf     <= (w_nxt == S_WB && w_wb_werf) || w_nxt == S_TRAP || w_nxt == S_IRQ;
      r_wasel    <= w_nxt == S_TRAP || w_nxt == S_IRQ;
      r_wdsel    <= w_nxt == S_WB ? w_wb_wdsel : WDSEL_PCINC;
      r_cause    <= w_nxt == S_TRAP ? (r_state == S_EXEC ? CAUSE_ILLOP : CAUSE_BUSERR) :
                    w_nxt == S_IRQ ? CAUSE_IRQ : r_cause;
      r_cnt      <= r_state == S_WB ? r_cnt + 32'd1 : r_cnt;
    end

  assign PCSEL      = r_pcsel;
  assign PC_EN      = r_pc_en;
  assign IR_LD      = IMEM_RDY && r_imem_req;
  assign IMEM_REQ   = r_imem_req;
  assign DMEM_REQ   = r_dmem_req;
  assign DMEM_WE    = r_dmem_we;
  assign WERF       = r_werf;
  assign WASEL      = r_wasel;
  assign WDSEL      = r_wdsel;
  assign TRAP_CAUSE = r_cause;
  assign INSTR_CNT  = r_cnt;
endmodule

// File: tb/tb_beta_pc_sequencer.sv
// tb_beta_pc_sequencer: self-checking bench for the BETA control sequencer
module tb_beta_pc_sequencer;
  import beta_pkg::*;

  logic clk = 1'b0, rst_n = 1'b1;
  logic [2:0] opclass = OP_ALU;
  logic z = 1'b0, pc31 = 1'b0, irq = 1'b0, imem_rdy = 1'b0, dmem_rdy = 1'b0;
  logic [2:0] pcsel, t_pcsel;
  logic pc_en, ir_ld, imem_req, dmem_req, dmem_we, werf, wasel;
  logic t_pc_en, t_ir_ld, t_imem_req, t_dmem_req, t_dmem_we, t_werf, t_wasel;
  logic [1:0] wdsel, trap_cause, t_wdsel, t_trap_cause;
  logic [31:0] instr_cnt, t_instr_cnt;
  int n_vec = 0, n_err = 0;

  always #5 clk = ~clk;

  beta_pc_sequencer u_dut (
    .CLK(clk), .RESET_N(rst_n), .OPCLASS(opclass), .Z(z), .PC31(pc31), .IRQ(irq),
    .IMEM_RDY(imem_rdy), .DMEM_RDY(dmem_rdy), .PCSEL(pcsel), .PC_EN(pc_en), .IR_LD(ir_ld),
    .IMEM_REQ(imem_req), .DMEM_REQ(dmem_req), .DMEM_WE(dmem_we), .WERF(werf), .WASEL(wasel),
    .WDSEL(wdsel), .TRAP_CAUSE(trap_cause), .INSTR_CNT(instr_cnt)
  );

  beta_pc_sequencer #(.TIMEOUT(4), .TO_W(8)) u_to (
    .CLK(clk), .RESET_N(rst_n), .OPCLASS(opclass), .Z(z), .PC31(pc31), .IRQ(irq),
    .IMEM_RDY(imem_rdy), .DMEM_RDY(dmem_rdy), .PCSEL(t_pcsel), .PC_EN(t_pc_en), .IR_LD(t_ir_ld),
    .IMEM_REQ(t_imem_req), .DMEM_REQ(t_dmem_req), .DMEM_WE(t_dmem_we), .WERF(t_werf),
    .WASEL(t_wasel), .WDSEL(t_wdsel), .TRAP_CAUSE(t_trap_cause), .INSTR_CNT(t_instr_cnt)
  );

  wire [13:0] obs   = {pc_en, pcsel, ir_ld, imem_req, dmem_req, dmem_we, werf, wasel, wdsel, trap_cause};
  wire [13:0] t_obs = {t_pc_en, t_pcsel, t_ir_ld, t_imem_req, t_dmem_req, t_dmem_we, t_werf, t_wasel,
                       t_wdsel, t_trap_cause};

  // Expected output vector in the same field order as obs.
  function automatic logic [13:0] e(input logic pe, input logic [2:0] ps, input logic ir, im, dr, dw,
                                    wf, wa, input logic [1:0] wd, tc);
    return {pe, ps, ir, im, dr, dw, wf, wa, wd, tc};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench 1 time unit after the first edge following reset release (idle fetch slot).
  task automatic do_reset;
    irq = 0; dmem_rdy = 0; pc31 = 0; z = 0;
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
  endtask

  task automatic test_reset;
    imem_rdy = 1;
    #1 rst_n = 0;
    #2;
    n_vec++;
    if (obs !== 14'd0 || instr_cnt !== 32'd0 || ir_ld !== 1'b0) begin
      n_err++;
      $display("FAIL reset_outputs: got %h cnt %0d, want 0 cnt 0", obs, instr_cnt);
    end
    @(posedge clk);
    #1 rst_n = 1;
    @(negedge clk);
    n_vec++;
    if ({imem_req, pc_en, werf, dmem_req} !== 4'b0) begin
      n_err++;
      $display("FAIL release_no_req: got req/pc_en/werf/dreq %b, want 0000", {imem_req, pc_en, werf, dmem_req});
    end
  endtask

  task automatic test_alu;
    logic [13:0] exp_v[4];
    logic [31:0] exp_c[4];
    exp_v = '{e(0,0,1,1,0,0,0,0,0,0), 14'd0, e(1,PCSEL_INC,0,0,0,0,1,0,WDSEL_ALU,0), e(0,0,1,1,0,0,0,0,0,0)};
    exp_c = '{32'd0, 32'd0, 32'd0, 32'd1};
    opclass = OP_ALU; imem_rdy = 1;
    do_reset;
    for (int c = 0; c < 4; c++) begin
      tick;
      @(negedge clk);
      n_vec++;
      if (obs !== exp_v[c] || instr_cnt !== exp_c[c]) begin
        n_err++;
        $display("FAIL alu_cycle%0d: got %h cnt %0d, want %h cnt %0d", c + 1, obs, instr_cnt, exp_v[c], exp_c[c]);
      end
    end
  endtask

  task automatic test_branches;
    logic [2:0] ops[4] = '{OP_BEQ, OP_BNE, OP_JMP, OP_BNE};
    logic       zs[4]  = '{1'b1, 1'b1, 1'b1, 1'b0};
    logic [2:0] eps[4] = '{PCSEL_OFFSET, PCSEL_INC, PCSEL_JT, PCSEL_OFFSET};
    imem_rdy = 1;
    do_reset;
    for (int k = 0; k < 4; k++) begin
      opclass = ops[k]; z = zs[k];
      repeat (3) tick;
      @(negedge clk);
      n_vec++;
      if (obs !== e(1, eps[k], 0, 0, 0, 0, 1, 0, WDSEL_PCINC, 0) || instr_cnt !== 32'(k)) begin
        n_err++;
        $display("FAIL branch_wb%0d: got %h cnt %0d, want %h cnt %0d", k, obs, instr_cnt,
                 e(1, eps[k], 0, 0, 0, 0, 1, 0, WDSEL_PCINC, 0), k);
      end
    end
  endtask

  task automatic test_st_wait;
    imem_rdy = 1; opclass = OP_ST;
    do_reset;
    tick;
    tick;
    imem_rdy = 0;
    for (int k = 0; k < 5; k++) begin
      tick;
      dmem_rdy = (k == 4);
      @(negedge clk);
      n_vec++;
      if (obs !== e(0, 0, 0, 0, 1, 1, 0, 0, 0, 0)) begin
        n_err++;
        $display("FAIL st_mem%0d: got %h, want %h", k, obs, e(0, 0, 0, 0, 1, 1, 0, 0, 0, 0));
      end
    end
    tick;
    dmem_rdy = 0;
    @(negedge clk);
    n_vec++;
    if ({pc_en, pcsel, werf, wasel, dmem_req, dmem_we} !== 8'b1000_0000) begin
      n_err++;
      $display("FAIL st_wb: got pc_en/pcsel/werf/wasel/dreq/we %b, want 10000000",
               {pc_en, pcsel, werf, wasel, dmem_req, dmem_we});
    end
    tick;
    @(negedge clk);
    n_vec++;
    if (instr_cnt !== 32'd1) begin
      n_err++;
      $display("FAIL st_retire: got %0d, want 1", instr_cnt);
    end
  endtask

  task automatic test_timeout;
    imem_rdy = 0; opclass = OP_ALU;
    do_reset;
    for (int k = 1; k <= 4; k++) begin
      tick;
      @(negedge clk);
      n_vec++;
      if (t_obs !== e(0, 0, 0, 1, 0, 0, 0, 0, 0, 0)) begin
        n_err++;
        $display("FAIL to_wait%0d: got %h, want %h", k, t_obs, e(0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
      end
    end
    tick;
    @(negedge clk);
    n_vec++;
    if (t_obs !== e(1, PCSEL_ILLOP, 0, 0, 0, 0, 1, 1, 0, CAUSE_BUSERR) || t_instr_cnt !== 32'd0) begin
      n_err++;
      $display("FAIL to_trap: got %h cnt %0d, want %h cnt 0", t_obs, t_instr_cnt,
               e(1, PCSEL_ILLOP, 0, 0, 0, 0, 1, 1, 0, CAUSE_BUSERR));
    end
    for (int k = 1; k <= 4; k++) begin
      tick;
      imem_rdy = (k == 4);
      @(negedge clk);
    end
    tick;
    imem_rdy = 0;
    @(negedge clk);
    n_vec++;
    if (t_obs !== e(0, 0, 0, 0, 0, 0, 0, 0, 0, CAUSE_BUSERR)) begin
      n_err++;
      $display("FAIL to_rdy_wins: got %h, want %h", t_obs, e(0, 0, 0, 0, 0, 0, 0, 0, 0, CAUSE_BUSERR));
    end
  endtask

  task automatic test_irq;
    logic pcs[4]   = '{1'b0, 1'b1, 1'b1, 1'b0};
    logic irqs[4]  = '{1'b1, 1'b1, 1'b0, 1'b0};
    logic takes[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    logic [1:0] cause = CAUSE_NONE;
    imem_rdy = 1; opclass = OP_ALU;
    do_reset;
    tick;
    for (int k = 0; k < 4; k++) begin
      pc31 = pcs[k];
      tick;
      irq = irqs[k];
      tick;
      irq = 0;
      @(negedge clk);
      n_vec++;
      if (obs !== e(1, PCSEL_INC, 0, 0, 0, 0, 1, 0, WDSEL_ALU, cause)) begin
        n_err++;
        $display("FAIL irq_wb%0d: got %h, want %h", k, obs, e(1, PCSEL_INC, 0, 0, 0, 0, 1, 0, WDSEL_ALU, cause));
      end
      tick;
      if (takes[k]) begin
        cause = CAUSE_IRQ;
        @(negedge clk);
        n_vec++;
        if (obs !== e(1, PCSEL_XADR, 0, 0, 0, 0, 1, 1, 0, CAUSE_IRQ)) begin
          n_err++;
          $display("FAIL irq_take%0d: got %h, want %h", k, obs, e(1, PCSEL_XADR, 0, 0, 0, 0, 1, 1, 0, CAUSE_IRQ));
        end
        tick;
      end
      @(negedge clk);
      n_vec++;
      if (obs !== e(0, 0, 1, 1, 0, 0, 0, 0, 0, cause)) begin
        n_err++;
        $display("FAIL irq_fetch%0d: got %h, want %h", k, obs, e(0, 0, 1, 1, 0, 0, 0, 0, 0, cause));
      end
    end
  endtask

  task automatic test_reset_mid;
    imem_rdy = 1; opclass = OP_LD;
    do_reset;
    repeat (4) tick;
    @(negedge clk);
    #2 rst_n = 0;
    dmem_rdy = 1;
    #1;
    n_vec++;
    if (obs !== 14'd0 || instr_cnt !== 32'd0) begin
      n_err++;
      $display("FAIL reset_async: got %h cnt %0d, want 0 cnt 0", obs, instr_cnt);
    end
    tick;
    n_vec++;
    if (pc_en !== 1'b0 || werf !== 1'b0 || instr_cnt !== 32'd0) begin
      n_err++;
      $display("FAIL reset_no_pulse: got pc_en %b werf %b cnt %0d, want 0 0 0", pc_en, werf, instr_cnt);
    end
    rst_n = 1; dmem_rdy = 0;
  endtask

  typedef struct { logic ir, dr, iq; logic [13:0] ex; logic [31:0] cn; } cyc_t;

  // Transaction-level model: each instruction expands into the phases it must visit.
  task automatic test_random_program(input int n);
    cyc_t q[$];
    logic [31:0] cnt = 0;
    logic [1:0] cause = CAUSE_NONE, wd;
    logic pending = 0, irq_en;
    logic [2:0] op, ps;
    int iw, dw;
    do_reset;
    tick;
    for (int i = 0; i < n; i++) begin
      op = 3'($urandom_range(0, 7));
      z = 1'($urandom);
      pc31 = ($urandom_range(0, 2) == 0);
      iw = $urandom_range(0, 3);
      dw = $urandom_range(0, 3);
      irq_en = ($urandom_range(0, 3) == 0);
      opclass = op;
      q = {};
      for (int c = 0; c <= iw; c++) q.push_back('{c == iw, 1'b0, 1'b0, e(0, 0, c == iw, 1, 0, 0, 0, 0, 0, cause), cnt});
      q.push_back('{1'b0, 1'b0, irq_en, e(0, 0, 0, 0, 0, 0, 0, 0, 0, cause), cnt});
      if (irq_en) pending = 1;
      if (op == OP_ILL) begin
        cause = CAUSE_ILLOP;
        q.push_back('{1'b0, 1'b0, 1'b0, e(1, PCSEL_ILLOP, 0, 0, 0, 0, 1, 1, 0, cause), cnt});
      end else begin
        if (op == OP_LD || op == OP_ST || op == OP_LDR)
          for (int c = 0; c <= dw; c++) q.push_back('{1'b0, c == dw, 1'b0, e(0, 0, 0, 0, 1, op == OP_ST, 0, 0, 0, cause), cnt});
        ps = op == OP_JMP ? PCSEL_JT : op == OP_BEQ ? (z ? PCSEL_OFFSET : PCSEL_INC) :
             op == OP_BNE ? (z ? PCSEL_INC : PCSEL_OFFSET) : PCSEL_INC;
        wd = op == OP_ALU ? WDSEL_ALU : (op == OP_LD || op == OP_LDR) ? WDSEL_MEM : WDSEL_PCINC;
        q.push_back('{1'b0, 1'b0, 1'b0, e(1, ps, 0, 0, 0, 0, op != OP_ST, 0, wd, cause), cnt});
        cnt++;
        if (pending && !pc31) begin
          cause = CAUSE_IRQ;
          pending = 0;
          q.push_back('{1'b0, 1'b0, 1'b0, e(1, PCSEL_XADR, 0, 0, 0, 0, 1, 1, 0, cause), cnt});
        end
      end
      foreach (q[j]) begin
        imem_rdy = q[j].ir; dmem_rdy = q[j].dr; irq = q[j].iq;
        @(negedge clk);
        n_vec++;
        if (obs !== q[j].ex || instr_cnt !== q[j].cn) begin
          n_err++;
          $display("FAIL random_i%0d_c%0d op%0d: got %h cnt %0d, want %h cnt %0d", i, j, op, obs, instr_cnt,
                   q[j].ex, q[j].cn);
        end
        tick;
      end
    end
    imem_rdy = 0; dmem_rdy = 0; irq = 0;
  endtask

  initial begin
    test_reset;
    test_alu;
    test_branches;
    test_st_wait;
    test_timeout;
    test_irq;
    test_reset_mid;
    test_random_program(60);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/beta_pc_sequencer.md
Name: beta_pc_sequencer

Overview:
Multi-cycle control sequencer for the BETA core. It steps each instruction through fetch, execute, memory access and writeback, and handshakes with instruction and data memory. It drives the PC unit's PCSEL and update enable, plus the register-file write controls. It also latches interrupts and raises the ILLOP and XADR traps, including a memory-timeout bus-error trap.

Parameters:
TIMEOUT, 255, maximum wait cycles for IMEM_RDY/DMEM_RDY before a bus-error trap; 0 disables the timeout
TO_W, 8, timeout counter width; TIMEOUT must be less than 2**TO_W

Ports:
CLK  in  1  clock, rising edge
RESET_N  in  1  asynchronous active-low reset
OPCLASS  in  3  decoded class of the current IR; encodings in the package
Z  in  1  Ra==0 flag from the register file
PC31  in  1  supervisor bit, PC[31]
IRQ  in  1  external interrupt request, level; rising edge is captured
IMEM_RDY  in  1  instruction word valid
DMEM_RDY  in  1  data access complete
PCSEL  out  3  to the PC unit: 0 INC, 1 OFFSET, 2 JT, 3 ILLOP, 4 XADR
PC_EN  out  1  the PC unit updates only in a cycle where this is 1
IR_LD  out  1  load IR from the instruction bus
IMEM_REQ  out  1  instruction fetch request
DMEM_REQ  out  1  data request
DMEM_WE  out  1  data write (ST)
WERF  out  1  register-file write enable
WASEL  out  1  0 selects Rc, 1 selects XP (R30)
WDSEL  out  2  write-data select: 0 PC_INC, 1 ALU, 2 MEM
TRAP_CAUSE  out  2  cause of the last trap: 0 none, 1 illegal op, 2 bus error, 3 interrupt
INSTR_CNT  out  32  retired-instruction counter

Behaviour:
- Reset (async assert, sync release): state S_FETCH.
  - All outputs 0; INSTR_CNT 0; TRAP_CAUSE 0; pending-IRQ flag 0; timeout counter 0.
  - IMEM_REQ first rises in the first clock edge after RESET_N deasserts.
  - Reset asserted mid-instruction aborts it immediately, with no PC_EN or WERF pulse.
- Outputs are Moore-registered per state. IR_LD is the exception: it is combinational, IMEM_RDY AND state==S_FETCH.
- S_FETCH:
  - IMEM_REQ=1, held until IMEM_RDY is sampled high.
  - On IMEM_RDY: IR_LD=1, next state S_EXEC.
- S_EXEC: one cycle; OPCLASS is valid here.
  - OP_ILL -> S_TRAP with cause 1.
  - OP_LD, OP_ST, OP_LDR -> S_MEM.
  - All other classes -> S_WB.
- S_MEM:
  - DMEM_REQ=1; DMEM_WE=1 only for OP_ST.
  - Held until DMEM_RDY, then -> S_WB.
- Timeout (S_FETCH and S_MEM only):
  - Counter clears on state entry and increments each waiting cycle.
  - Reaching TIMEOUT-1 without RDY -> S_TRAP with cause 2.
  - RDY in that same cycle wins.
- S_WB: one cycle, PC_EN=1.
  - PCSEL: ALU/LD/ST/LDR -> 0; JMP -> 2; BEQ -> (Z ? 1 : 0); BNE -> (Z ? 0 : 1).
  - WERF=0 for ST, 1 otherwise.
  - WDSEL: 0 for BEQ/BNE/JMP, 1 for ALU, 2 for LD/LDR.
  - WASEL=0.
  - INSTR_CNT increments, wrapping at 2^32.
  - Next state S_IRQ if pending AND PC31==0, else S_FETCH.
- S_TRAP: one cycle; PC_EN=1, PCSEL=3, WERF=1, WASEL=1, WDSEL=0; TRAP_CAUSE updated; -> S_FETCH. No retire.
- S_IRQ: one cycle; PC_EN=1, PCSEL=4, WERF=1, WASEL=1, WDSEL=0; TRAP_CAUSE=3; pending cleared; -> S_FETCH.
- IRQ capture:
  - A registered rising-edge detect sets the pending flag in any state.
  - A set coinciding with the clear in S_IRQ leaves pending=1.
  - Pending persists while in supervisor mode (PC31==1) and is taken after the first WB executed in user mode.
- The timeout counter saturates and never wraps.
- Unused OPCLASS encodings are treated as OP_ILL.
- Throughput: 3 cycles per ALU or branch instruction with zero-wait memory; 4 cycles for LD/ST/LDR.

Decomposition:
- Package beta_pkg:
  - OPCLASS localparams: OP_ALU=0, OP_LD=1, OP_ST=2, OP_LDR=3, OP_BEQ=4, OP_BNE=5, OP_JMP=6, OP_ILL=7.
  - PCSEL codes PCSEL_INC..PCSEL_XADR (0..4).
  - WDSEL codes.
  - TRAP_CAUSE codes.
  - State encoding: S_FETCH, S_EXEC, S_MEM, S_WB, S_TRAP, S_IRQ.
- One sub-module, beta_irq_latch: edge detect plus pending flag with set-over-clear priority.

Test Plan:
1. Reset release, IMEM_RDY tied 1, OPCLASS=OP_ALU. Expect IMEM_REQ in cycle 1, IR_LD in cycle 1, PC_EN/WERF=1 with WDSEL=1 and PCSEL=0 in cycle 3, INSTR_CNT=1 after cycle 3.
2. OP_BEQ with Z=1. Expect PCSEL=1 in WB. OP_BNE with Z=1: PCSEL=0. OP_JMP: PCSEL=2, WDSEL=0.
3. OP_ST with DMEM_RDY delayed 5 cycles. Expect DMEM_REQ=DMEM_WE=1 for 5 cycles, then WB with WERF=0.
4. TIMEOUT=4, IMEM_RDY held 0. Expect S_TRAP after 4 waiting cycles: PCSEL=3, WASEL=1, TRAP_CAUSE=2, INSTR_CNT unchanged.
5. IRQ pulse during S_EXEC with PC31=0. Expect WB followed by S_IRQ: PCSEL=4, WERF=1, WASEL=1, TRAP_CAUSE=3. Repeat with PC31=1: no S_IRQ until PC31 returns to 0.
6. RESET_N asserted in the S_MEM wait. Expect all outputs 0 asynchronously, and no PC_EN pulse at the next edge.
